pe_array_piso: RTL and testbench
================================

Name: pe_array_piso

Overview:
- Output serializer directly downstream of the PE array.
- Captures the concatenated per-PE result bus (PE_NUM lanes of 2*DATA_WIDTH bits) on a load strobe.
- Streams the lanes out one per cycle, PE_0 first, with valid/ready backpressure.
- Double-buffered: one snapshot can be captured while the previous one is still draining, so back-to-back frames have no bubble.

Parameters:
- PE_NUM, 8, number of PE lanes in p_in.
- DATA_WIDTH, 16, half-lane width; each lane and s_out are 2*DATA_WIDTH bits.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- load  in  1  capture request for p_in; ignored when load_rdy=0 (counts as overflow).
- p_in  in  PE_NUM*2*DATA_WIDTH  parallel PE results; lane k = bits [(k+1)*2*DATA_WIDTH-1 : k*2*DATA_WIDTH].
- load_rdy  out  1  1 when a load is accepted this cycle.
- s_out_v  out  1  serial word valid.
- s_out  out  2*DATA_WIDTH  serial word.
- s_out_rdy  in  1  downstream ready; a beat transfers when s_out_v && s_out_rdy.
- overflow  out  1  sticky; set when load=1 while load_rdy=0.

Behaviour:
- Storage: shift register sreg (PE_NUM lanes), shadow register shd with valid flag shd_v, lane counter cnt (0..PE_NUM-1), FSM {IDLE, SHIFT}.
- Reset (rst=0, async): state=IDLE, cnt=0, shd_v=0, s_out_v=0, s_out=0, overflow=0, sreg/shd cleared. Reset mid-frame discards all data and emits no further beats.
- load_rdy = !shd_v (combinational).
- IDLE + load:
  - sreg<=p_in, cnt<=0, state<=SHIFT.
  - s_out_v=1 with s_out=lane 0 on the next cycle (1-cycle latency).
- SHIFT:
  - s_out = sreg lane 0.
  - s_out and s_out_v are held stable while s_out_rdy=0.
- Handshake, cnt<PE_NUM-1: sreg shifts right by 2*DATA_WIDTH (zero fill), cnt<=cnt+1.
- Handshake, cnt==PE_NUM-1 (last beat), priority order:
  - (a) shd_v=1: sreg<=shd, shd_v<=0, cnt<=0, stay SHIFT; no bubble. A load in that cycle is refused (load_rdy=0) and flags overflow.
  - (b) shd_v=0 and load=1: sreg<=p_in, cnt<=0, stay SHIFT; no bubble.
  - (c) otherwise: state<=IDLE, s_out_v<=0, s_out<=0.
- SHIFT + load, not case (b), shd_v=0: shd<=p_in, shd_v<=1.
- Load while shd_v=1: p_in dropped, overflow<=1. overflow is cleared only by reset.
- s_out_rdy is don't-care while s_out_v=0.
- Throughput: PE_NUM beats per frame; a continuous stream is sustained if load occurs at most once per PE_NUM cycles.

Optional Feature:
- Macro PISO_LAST_EN.
- Defined:
  - Adds output port s_out_last (1 bit), asserted with s_out_v when cnt==PE_NUM-1, held with the data under backpressure, reset 0.
  - Adds output frame_cnt (16 bits): increments on every last-beat handshake, wraps 0xFFFF->0, reset 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Basic frame: PE_NUM=8, DATA_WIDTH=16, p_in lane k = 0xA0000000+k, one load, s_out_rdy=1 -> 8 consecutive beats 0xA0000000..0xA0000007 starting 1 cycle after load, then s_out_v=0; overflow=0.
- Backpressure: same frame, s_out_rdy low on beats 2 and 5 for 3 cycles each -> s_out frozen at 0xA0000002/0xA0000005 during the stalls; order intact; 8 beats total.
- Back-to-back: load frame A (lanes 0x1..0x8), load frame B (lanes 0x11..0x18) 3 cycles later, rdy=1 -> 16 contiguous beats 0x1..0x8, 0x11..0x18, no gap; load_rdy low from B's capture until A's last beat.
- Overflow: loads A, B, C on cycles 0, 1, 2 with rdy=0 -> load_rdy=0 at cycle 2, overflow=1 from cycle 3 and stays; only A then B are emitted after rdy rises.
- Reset mid-frame: drive rst=0 asynchronously after beat 3 of a frame -> s_out_v, s_out, overflow are 0 immediately. After release, a new load of 0xB0000000+k streams cleanly from lane 0.
- PISO_LAST_EN: two frames -> s_out_last high only on beats 0xA0000007 and the second frame's lane 7; frame_cnt reads 1 then 2.

Source files
------------

// File: rtl/pe_array_piso.sv
// pe_array_piso: double-buffered parallel-in/serial-out stage behind the PE array.
// A load snapshots all PE lanes. The lanes then stream out one per beat, lane 0 first,
// under valid/ready flow control. A shadow register accepts the next frame while the
// current frame is still draining.
// Optional macro PISO_LAST_EN adds the s_out_last and frame_cnt outputs.
module pe_array_piso #(
    parameter int unsigned PE_NUM     = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0] p_in,
    output logic                           load_rdy,
    output logic                           s_out_v,
    output logic [2*DATA_WIDTH-1:0]        s_out,
    input  logic                           s_out_rdy,
`ifdef PISO_LAST_EN
    output logic                           s_out_last,
    output logic [15:0]                    frame_cnt,
`endif
    output logic                           overflow
);

    localparam int unsigned LW = 2 * DATA_WIDTH;
    localparam int unsigned CW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(PE_NUM - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e                   state_q, state_d;
    logic [PE_NUM*LW-1:0]     sreg_q, sreg_d;
    logic [PE_NUM*LW-1:0]     shd_q, shd_d;
    logic                     shd_v_q, shd_v_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic                     hs;
    logic                     last;

    assign load_rdy = !shd_v_q;
    assign s_out_v  = (state_q == StShift);
    // Output is forced to zero outside a frame so that idle reads are clean
    assign s_out    = s_out_v ? sreg_q[LW-1:0] : '0;
    assign overflow = ovf_q;
    assign hs       = s_out_v && s_out_rdy;
    assign last     = (cnt_q == LastCnt);

    // Next-state: capture, shift, frame hand-over and overflow detection
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        shd_d   = shd_q;
        shd_v_d = shd_v_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | (load & shd_v_q);
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    sreg_d  = p_in;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (hs && !last) begin
                    sreg_d = sreg_q >> LW;
                    cnt_d  = cnt_q + 1'b1;
                end else if (hs && last) begin
                    cnt_d = '0;
                    if (shd_v_q) begin
                        // The buffered frame takes over with no bubble. A load this cycle is refused.
                        sreg_d  = shd_q;
                        shd_v_d = 1'b0;
                    end else if (load) begin
                        sreg_d = p_in;
                    end else begin
                        sreg_d  = '0;
                        state_d = StIdle;
                    end
                end
                // A load that does not replace the draining frame goes to the shadow register
                if (load && !shd_v_q && !(hs && last)) begin
                    shd_d   = p_in;
                    shd_v_d = 1'b1;
                end
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            shd_q   <= '0;
            shd_v_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            shd_q   <= shd_d;
            shd_v_q <= shd_v_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef PISO_LAST_EN
    logic [15:0] frame_cnt_q;

    assign s_out_last = s_out_v && last;
    assign frame_cnt  = frame_cnt_q;

    // Count completed frames, one per last-beat handshake; wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (hs && last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_array_piso.sv
// tb_pe_array_piso: directed test of pe_array_piso.
// Covers a basic frame, backpressure, back-to-back frames, overflow, and reset mid-frame.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pe_array_piso;

    localparam int unsigned PE_NUM     = 8;
    localparam int unsigned DATA_WIDTH = 16;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           load;
    logic [PE_NUM*2*DATA_WIDTH-1:0] p_in;
    logic                           load_rdy;
    logic                           s_out_v;
    logic [2*DATA_WIDTH-1:0]        s_out;
    logic                           s_out_rdy;
    logic                           overflow;
`ifdef PISO_LAST_EN
    logic                           s_out_last;
    logic [15:0]                    frame_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pe_array_piso #(
        .PE_NUM    (PE_NUM),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .p_in      (p_in),
        .load_rdy  (load_rdy),
        .s_out_v   (s_out_v),
        .s_out     (s_out),
        .s_out_rdy (s_out_rdy),
`ifdef PISO_LAST_EN
        .s_out_last(s_out_last),
        .frame_cnt (frame_cnt),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [PE_NUM*2*DATA_WIDTH-1:0] mk(input logic [31:0] base);
        logic [PE_NUM*2*DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < int'(PE_NUM); k++) r[k*32 +: 32] = base + 32'(k);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; p_in = '0; s_out_rdy = 1'b1;
        #12;
        chk("rst_v", 32'(s_out_v), 32'd0);
        chk("rst_data", s_out, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_lrdy", 32'(load_rdy), 32'd1);
        rst = 1'b1;
        tick();

        // Basic frame
        load = 1'b1; p_in = mk(32'hA000_0000);
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("basic_v", 32'(s_out_v), 32'd1);
            chk("basic_data", s_out, 32'hA000_0000 + 32'(k));
`ifdef PISO_LAST_EN
            chk("basic_last", 32'(s_out_last), (k == 7) ? 32'd1 : 32'd0);
`endif
            tick();
        end
        chk("basic_idle_v", 32'(s_out_v), 32'd0);
        chk("basic_idle_data", s_out, 32'd0);
        chk("basic_ovf", 32'(overflow), 32'd0);
`ifdef PISO_LAST_EN
        chk("frame_cnt1", 32'(frame_cnt), 32'd1);
`endif

        // Backpressure: stall 3 cycles on beats 2 and 5
        load = 1'b1; p_in = mk(32'hA000_0000);
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2 || k == 5) begin
                s_out_rdy = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk("bp_stall_v", 32'(s_out_v), 32'd1);
                    chk("bp_stall_data", s_out, 32'hA000_0000 + 32'(k));
`ifdef PISO_LAST_EN
                    chk("bp_stall_last", 32'(s_out_last), 32'd0);
`endif
                    tick();
                end
                s_out_rdy = 1'b1;
            end
            chk("bp_v", 32'(s_out_v), 32'd1);
            chk("bp_data", s_out, 32'hA000_0000 + 32'(k));
`ifdef PISO_LAST_EN
            chk("bp_last", 32'(s_out_last), (k == 7) ? 32'd1 : 32'd0);
`endif
            tick();
        end
        chk("bp_idle_v", 32'(s_out_v), 32'd0);
`ifdef PISO_LAST_EN
        chk("frame_cnt2", 32'(frame_cnt), 32'd2);
`endif

        // Back-to-back: frame B loaded 3 cycles after A
        load = 1'b1; p_in = mk(32'h0000_0001);
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("b2b_v", 32'(s_out_v), 32'd1);
            chk("b2b_data", s_out, (i < 8) ? 32'(1 + i) : 32'(32'h11 + i - 8));
            chk("b2b_lrdy", 32'(load_rdy), (i >= 3 && i <= 7) ? 32'd0 : 32'd1);
            if (i == 2) begin
                load = 1'b1; p_in = mk(32'h0000_0011);
            end
            tick();
            load = 1'b0;
        end
        chk("b2b_idle_v", 32'(s_out_v), 32'd0);
        chk("b2b_ovf", 32'(overflow), 32'd0);

        // Overflow: A, B, C on consecutive cycles while stalled
        s_out_rdy = 1'b0;
        load = 1'b1; p_in = mk(32'h0000_0100);
        tick();
        chk("ovf_lrdy1", 32'(load_rdy), 32'd1);
        p_in = mk(32'h0000_0200);
        tick();
        chk("ovf_lrdy2", 32'(load_rdy), 32'd0);
        chk("ovf_pre", 32'(overflow), 32'd0);
        p_in = mk(32'h0000_0300);
        tick();
        load = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        tick();
        tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_hold_data", s_out, 32'h0000_0100);
        s_out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_v", 32'(s_out_v), 32'd1);
            chk("ovf_data", s_out, (i < 8) ? 32'(32'h100 + i) : 32'(32'h200 + i - 8));
            tick();
        end
        chk("ovf_idle_v", 32'(s_out_v), 32'd0);
        chk("ovf_still", 32'(overflow), 32'd1);

        // Reset mid-frame after beat 3
        load = 1'b1; p_in = mk(32'hA000_0000);
        tick();
        load = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mid_data", s_out, 32'hA000_0004);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_v", 32'(s_out_v), 32'd0);
        chk("mr_data", s_out, 32'd0);
        chk("mr_ovf", 32'(overflow), 32'd0);
        tick();
        #2;
        rst = 1'b1;
        tick();
        chk("mr_post_v", 32'(s_out_v), 32'd0);
        load = 1'b1; p_in = mk(32'hB000_0000);
        tick();
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("mr_new_v", 32'(s_out_v), 32'd1);
            chk("mr_new_data", s_out, 32'hB000_0000 + 32'(k));
            tick();
        end
        chk("mr_new_idle", 32'(s_out_v), 32'd0);
`ifdef PISO_LAST_EN
        chk("frame_cnt_rst", 32'(frame_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
